// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared states, register map and load-order helper for pid_sequencer
package pid_pkg;

  localparam int NUM_PID_REGS = 4;

  localparam logic [1:0] KP_ADDR  = 2'd0;
  localparam logic [1:0] KI_ADDR  = 2'd1;
  localparam logic [1:0] KD_ADDR  = 2'd2;
  localparam logic [1:0] CFG_ADDR = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN,
    WAIT
  } pid_state_e;

  // Order in which the PID registers are written during LOAD; CFG is last.
  function automatic logic [1:0] next_reg_addr(input logic [1:0] addr);
    case (addr)
      KP_ADDR: return KI_ADDR;
      KI_ADDR: return KD_ADDR;
      KD_ADDR: return CFG_ADDR;
      default: return KP_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/pid_sample_timer.sv
// rtl/pid_sample_timer.sv - free-running modulo-SAMPLE_DIV counter with sync clear and tick
module pid_sample_timer #(
  parameter int SAMPLE_DIV = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: held at zero while cleared, otherwise wraps at SAMPLE_DIV-1.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (clear || (count_q == CNT_LAST)) begin
      count_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == CNT_LAST);

endmodule

// File: rtl/pid_sequencer.sv
// rtl/pid_sequencer.sv - PID register loader and periodic sampler; optional output clamp under PID_SEQ_SAT_EN
module pid_sequencer
  import pid_pkg::*;
#(
  parameter int D_WIDTH     = 16,
  parameter int SAMPLE_DIV  = 100,
  parameter int PID_LATENCY = 2
`ifdef PID_SEQ_SAT_EN
  ,
  parameter int OUT_MIN     = -1000,
  parameter int OUT_MAX     = 1000
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               host_we,
  input  logic [1:0]         host_addr,
  input  logic [D_WIDTH-1:0] host_data,
  input  logic               host_commit,
  input  logic [D_WIDTH-1:0] target_in,
  input  logic [D_WIDTH-1:0] meas_in,
  output logic               busy,
  output logic               pid_reset,
  output logic               pid_write_enable,
  output logic [15:0]        pid_reg_addr,
  output logic [D_WIDTH-1:0] pid_reg_data,
  output logic [D_WIDTH-1:0] pid_target,
  output logic [D_WIDTH-1:0] pid_measurement,
  input  logic [D_WIDTH-1:0] pid_out,
  output logic [D_WIDTH-1:0] ctrl_out,
  output logic               ctrl_valid
`ifdef PID_SEQ_SAT_EN
  ,
  output logic               sat_flag
`endif
);

  localparam int WAIT_W = $clog2(PID_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PID_LATENCY - 1);

  pid_state_e         state_q, state_d;
  logic [1:0]         load_idx_q, load_idx_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               pending_q, pending_d;
  logic [D_WIDTH-1:0] shadow_q [NUM_PID_REGS];
  logic [D_WIDTH-1:0] shadow_d [NUM_PID_REGS];
  logic [D_WIDTH-1:0] pid_target_q, pid_target_d;
  logic [D_WIDTH-1:0] pid_meas_q, pid_meas_d;
  logic [D_WIDTH-1:0] ctrl_out_q, ctrl_out_d;
  logic               ctrl_valid_q, ctrl_valid_d;

  logic               timer_clear;
  logic               sample_tick;
  logic               capture;
  logic [D_WIDTH-1:0] cap_value;

  pid_sample_timer #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_sample_timer (
    .clock(clock),
    .reset(reset),
    .clear(timer_clear),
    .tick (sample_tick)
  );

  // Capture happens on the last WAIT cycle, PID_LATENCY cycles after launch.
  assign capture = (state_q == WAIT) && (wait_cnt_q == WAIT_LAST);

`ifdef PID_SEQ_SAT_EN
  localparam logic signed [D_WIDTH-1:0] OUT_MIN_W = D_WIDTH'(OUT_MIN);
  localparam logic signed [D_WIDTH-1:0] OUT_MAX_W = D_WIDTH'(OUT_MAX);

  logic cap_sat;
  logic sat_q, sat_d;

  // Signed clamp of the PID result into [OUT_MIN, OUT_MAX].
  always_comb begin
    cap_value = pid_out;
    cap_sat   = 1'b0;
    if ($signed(pid_out) > OUT_MAX_W) begin
      cap_value = OUT_MAX_W;
      cap_sat   = 1'b1;
    end else if ($signed(pid_out) < OUT_MIN_W) begin
      cap_value = OUT_MIN_W;
      cap_sat   = 1'b1;
    end
  end

  // Saturation flag follows the most recent capture.
  always_comb begin
    sat_d = sat_q;
    if (capture) begin
      sat_d = cap_sat;
    end
  end

  // Saturation flag register.
  always_ff @(posedge clock) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`else
  assign cap_value = pid_out;
`endif

  // Host writes land in the shadows in any state; the PID only sees them on LOAD.
  always_comb begin
    shadow_d = shadow_q;
    if (host_we) begin
      shadow_d[host_addr] = host_data;
    end
  end

  // Sequencer next-state: clear, load four registers, then launch/capture samples.
  always_comb begin
    state_d      = state_q;
    load_idx_d   = load_idx_q;
    wait_cnt_d   = wait_cnt_q;
    pending_d    = pending_q;
    pid_target_d = pid_target_q;
    pid_meas_d   = pid_meas_q;
    ctrl_out_d   = ctrl_out_q;
    ctrl_valid_d = 1'b0;
    timer_clear  = 1'b1;
    case (state_q)
      IDLE: begin
        if (host_commit) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        load_idx_d = KP_ADDR;
        state_d    = LOAD;
      end
      LOAD: begin
        if (load_idx_q == CFG_ADDR) begin
          state_d = RUN;
        end else begin
          load_idx_d = next_reg_addr(load_idx_q);
        end
      end
      RUN: begin
        timer_clear = 1'b0;
        if (host_commit) begin
          state_d = CLEAR;
        end else if (sample_tick) begin
          pid_target_d = target_in;
          pid_meas_d   = meas_in;
          wait_cnt_d   = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        timer_clear = 1'b0;
        if (capture) begin
          ctrl_out_d   = cap_value;
          ctrl_valid_d = 1'b1;
          pending_d    = 1'b0;
          state_d      = (pending_q || host_commit) ? CLEAR : RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (host_commit) begin
            pending_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sequence in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      load_idx_q   <= '0;
      wait_cnt_q   <= '0;
      pending_q    <= 1'b0;
      pid_target_q <= '0;
      pid_meas_q   <= '0;
      ctrl_out_q   <= '0;
      ctrl_valid_q <= 1'b0;
      for (int i = 0; i < NUM_PID_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      load_idx_q   <= load_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      pending_q    <= pending_d;
      pid_target_q <= pid_target_d;
      pid_meas_q   <= pid_meas_d;
      ctrl_out_q   <= ctrl_out_d;
      ctrl_valid_q <= ctrl_valid_d;
      shadow_q     <= shadow_d;
    end
  end

  assign busy             = (state_q == CLEAR) || (state_q == LOAD);
  assign pid_reset        = (state_q != CLEAR);
  assign pid_write_enable = (state_q != LOAD);
  assign pid_reg_addr     = (state_q == LOAD) ? {14'd0, load_idx_q} : 16'd0;
  assign pid_reg_data     = (state_q == LOAD) ? shadow_q[load_idx_q] : '0;
  assign pid_target       = pid_target_q;
  assign pid_measurement  = pid_meas_q;
  assign ctrl_out         = ctrl_out_q;
  assign ctrl_valid       = ctrl_valid_q;

endmodule

// File: doc/pid_sequencer.md
Name: pid_sequencer

Overview:
- Configures and schedules one `pid` instance (D_WIDTH datapath, four gain/config registers at addresses 0..3).
- Holds host-written gain values in shadow registers.
- On commit, clears the PID, then writes the four registers in order and starts a periodic sample loop.
- Each sample presents target/measurement to the PID, waits the PID latency, and captures `out` with a valid strobe.
- Sits between the host register bus and the PID core.

Parameters:
- D_WIDTH, 16, data width of gains, target, measurement and out.
- SAMPLE_DIV, 100, clock cycles between sample launches (>=PID_LATENCY+2).
- PID_LATENCY, 2, cycles from measurement presented to PID `out` valid.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- host_we  in  1  shadow register write strobe
- host_addr  in  2  shadow register index 0..3
- host_data  in  D_WIDTH  shadow register data
- host_commit  in  1  one-cycle pulse: (re)load PID from shadows and run
- target_in  in  D_WIDTH  setpoint
- meas_in  in  D_WIDTH  plant measurement
- busy  out  1  high in CLEAR/LOAD
- pid_reset  out  1  PID reset, active-low
- pid_write_enable  out  1  PID register write strobe, active-low
- pid_reg_addr  out  16  PID register address
- pid_reg_data  out  D_WIDTH  PID register data
- pid_target  out  D_WIDTH  registered setpoint to PID
- pid_measurement  out  D_WIDTH  registered measurement to PID
- pid_out  in  D_WIDTH  PID result
- ctrl_out  out  D_WIDTH  captured control output
- ctrl_valid  out  1  one-cycle pulse when ctrl_out updates

Behaviour:
- Reset values:
  - state=IDLE, shadows=0, busy=0.
  - pid_reset=1 (released), pid_write_enable=1 (idle).
  - pid_reg_addr=0, pid_reg_data=0.
  - pid_target, pid_measurement, ctrl_out=0; ctrl_valid=0.
- Reset mid-operation aborts any sequence immediately; there are no partial writes after reset.
- Shadow writes: accepted in any state on host_we. Shadows are registered at the clock edge and do not affect the PID until the next commit.
- If host_we and host_commit occur in the same cycle, the write lands first and the load uses the new value.
- States:
  - IDLE: outputs idle. host_commit -> CLEAR.
  - CLEAR: pid_reset=0 for exactly 1 cycle -> LOAD.
  - LOAD: 4 cycles, idx 0..3. Each cycle drives pid_write_enable=0, pid_reg_addr=idx, pid_reg_data=shadow[idx]. After idx 3 -> RUN, with the sample counter loaded at 0.
  - RUN: the counter increments each cycle. When it reaches SAMPLE_DIV-1, it wraps to 0. On that cycle, pid_target<=target_in and pid_measurement<=meas_in (held until the next launch), and the FSM goes to WAIT. The first launch occurs SAMPLE_DIV cycles after entering RUN.
  - WAIT: counts PID_LATENCY cycles, then captures ctrl_out<=pid_out, pulses ctrl_valid for 1 cycle, and returns to RUN. The sample counter keeps running through WAIT, so the period is exactly SAMPLE_DIV.
- Commit in CLEAR/LOAD: ignored (busy=1).
- Commit in RUN: -> CLEAR on the next edge.
- Commit in WAIT: latched as pending. The capture and ctrl_valid complete, then the FSM goes to CLEAR instead of RUN.
- ctrl_out holds its last value across reloads and is not cleared by CLEAR.
- Widths: pid_reg_addr is the zero-extended 2-bit index. The counter width is $clog2(SAMPLE_DIV).

Optional Feature:
- Macro PID_SEQ_SAT_EN. Adds parameters OUT_MIN (default -1000) and OUT_MAX (default 1000), both signed.
- With the macro: the captured pid_out is treated as signed and clamped to [OUT_MIN, OUT_MAX] before ctrl_out. A 1-bit output sat_flag is high while the last capture was clamped (reset 0).
- Without the macro: ctrl_out=pid_out unmodified, and there is no sat_flag port.

Decomposition:
- pid_pkg holds:
  - the state enum (IDLE, CLEAR, LOAD, RUN, WAIT);
  - NUM_PID_REGS=4;
  - the register address constants (KP=0, KI=1, KD=2, CFG=3).
- Sub-module pid_sample_timer: a free-running modulo-SAMPLE_DIV counter with sync clear and a tick output. Tick is high on the count==SAMPLE_DIV-1 cycle, and clear restarts the count at 0.

Test Plan:
- Reset, then shadow writes 1,2,3,4 to addr 0..3 and commit:
  - pid_reset low for 1 cycle;
  - then 4 cycles of pid_write_enable=0 with addr/data (0,1),(1,2),(2,3),(3,4);
  - busy high for 5 cycles.
- SAMPLE_DIV=10, PID_LATENCY=2, target_in=50, meas_in=10, stub pid_out=40:
  - first launch 10 cycles after RUN entry;
  - ctrl_out=40 with a ctrl_valid pulse 2 cycles later;
  - the next pulse comes exactly 10 cycles after that.
- Commit asserted during WAIT:
  - the pending capture still emits ctrl_valid;
  - then CLEAR and a full LOAD sequence with the new shadows.
- host_we (addr 2, data 9) in the same cycle as host_commit -> the LOAD writes data 9 to addr 2.
- Reset asserted on LOAD idx 1:
  - the next cycle has pid_write_enable=1, state IDLE, and shadows 0;
  - no further writes.
- With PID_SEQ_SAT_EN, stub pid_out=2000 -> ctrl_out=1000, sat_flag=1. Then pid_out=-5 -> ctrl_out=-5, sat_flag=0.
